tmr_vote_ctrl: RTL and testbench
================================

// Module: tmr_vote_ctrl
// PURPOSE
//   Sequenced triple-modular-redundancy voting controller for three redundant WIDTH-bit channels.
//   - Accepts one sample per valid/ready handshake and produces a bitwise 2-of-3 majority word.
//   - Tracks a consecutive-mismatch count per channel and retires a channel as FAILED at ERR_TH.
//   - Degrades TMR -> DMR -> SIMPLEX as channels fail.
//   - Sits between the redundant channel registers and downstream consumers, with one output register stage.
// PARAMETERS
//   WIDTH   8  data width of each channel and of out_data
//   ERR_TH  3  consecutive mismatching samples that mark a channel FAILED (1..2**CW-1)
//   CW      2  width of per-channel consecutive-mismatch counters
//   CNT_W   8  width of saturating total-error counter
// PORTS
//   clk        in   1      single clock, all logic on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      ch_a/ch_b/ch_c hold a sample
//   in_ready   out  1      controller can accept a sample this cycle
//   ch_a       in   WIDTH  channel A word
//   ch_b       in   WIDTH  channel B word
//   ch_c       in   WIDTH  channel C word
//   fail_clr   in   1      1-cycle pulse: restore all channels to HEALTHY, clear all counters
//   out_valid  out  1      out_data/out_flags valid
//   out_ready  in   1      downstream accepts out_data
//   out_data   out  WIDTH  voted word
//   out_err    out  3      {c,b,a}: channel disagreed with voted word on this sample
//   no_maj     out  1      DMR mode with the two healthy channels unequal (result unverified)
//   ch_fail    out  3      {c,b,a} sticky FAILED status
//   mode       out  2      0=TMR, 1=DMR, 2=SIMPLEX, 3=NONE (all failed)
//   err_total  out  CNT_W  saturating count of accepted samples with out_err!=0 or no_maj
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_err=0, no_maj=0, ch_fail=0, mode=0, err_total=0, mismatch counters=0.
// - Handshake:
//   - in_ready = !out_valid | out_ready.
//   - A sample is accepted when in_valid & in_ready.
//   - Accepted results appear on the next cycle (latency 1) with out_valid=1.
//   - Outputs hold stable while out_valid & !out_ready.
//   - out_valid drops after a transfer when no new sample is accepted that cycle.
//   - Full throughput: 1 sample/cycle when out_ready stays high.
// - Mode: mode is set by popcount(ch_fail): 0->TMR, 1->DMR, 2->SIMPLEX, 3->NONE.
// - Vote per mode:
//   - TMR: out_data = (a&b)|(a&c)|(b&c).
//   - DMR: out_data = lower-lettered healthy channel. no_maj=1 if the two healthy channels differ.
//   - SIMPLEX: out_data = the single healthy channel.
//   - NONE: out_data = ch_a, no_maj=1.
// - Mismatch detection:
//   - out_err[x] = healthy channel x != out_data. Failed channels always report out_err[x]=0.
//   - In DMR, a disagreement sets no_maj but increments no counter (fault not attributable).
// - Per-channel FSM (HEALTHY/SUSPECT/FAILED):
//   - HEALTHY -> SUSPECT on the first mismatch (counter=1).
//   - SUSPECT: each mismatch increments the counter; a matching sample clears it and returns to HEALTHY.
//   - SUSPECT -> FAILED when the counter reaches ERR_TH. ch_fail[x] sets on the cycle the result is registered.
//   - FAILED is sticky until rst or fail_clr; the counter is frozen.
//   - Counters update only on accepted samples.
// - Simultaneous faults: if two channels reach ERR_TH on the same sample, both fail.
//   - Mode jumps directly TMR->SIMPLEX.
//   - A new mode applies from the next accepted sample; the sample that caused the failure is voted in the old mode.
// - fail_clr:
//   - On the next edge: ch_fail=0, all counters=0, mode=TMR. err_total is not cleared.
//   - If a sample is accepted in the same cycle, it is voted in the pre-clear mode and its output is registered normally.
//   - Its mismatches are discarded: clear wins over counter increment.
// - err_total: increments by 1 per accepted sample with |out_err | no_maj. Saturates at 2**CNT_W-1.
// - Reset mid-operation: rst overrides everything; an in-flight output is dropped (out_valid=0 next cycle).
// TESTING
// - TMR vote: a=8'hF0 b=8'hF0 c=8'h0F -> out_data=8'hF0, out_err=3'b100, no_maj=0, 1 cycle latency.
// - Channel retirement:
//   - 3 consecutive samples with c wrong (ERR_TH=3) -> ch_fail=3'b100 after the 3rd; mode=1 on the next sample.
//   - A match after 2 mismatches -> no fail.
// - DMR disagreement: with c failed, a=8'h11 b=8'h22 -> out_data=8'h11, no_maj=1, err_total+1, counters unchanged.
// - Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_data stable, no sample lost or duplicated.
// - fail_clr + sample in the same cycle with a wrong -> ch_fail=0, a counter=0, mode=TMR, out_err[0]=1 on that output.
// - Saturation/reset:
//   - CNT_W=2, 5 erroneous samples -> err_total=3.
//   - rst asserted while out_valid=1 -> out_valid=0 and all outputs at reset values next cycle.

Source files
------------

// File: rtl/tmr_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tmr_vote_ctrl
// Brief   : TMR majority voter with per-channel retirement and TMR/DMR/SIMPLEX
//           degradation, one registered output stage with valid/ready.
// Revision: 1.0 - initial release
// ============================================================================
module tmr_vote_ctrl #(
   parameter int WIDTH  = 8,
   parameter int ERR_TH = 3,
   parameter int CW     = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ch_a,
   input  logic [WIDTH-1:0] ch_b,
   input  logic [WIDTH-1:0] ch_c,
   input  logic             fail_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       out_err,
   output logic             no_maj,
   output logic [2:0]       ch_fail,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] err_total
);

   localparam logic [CW-1:0] c_ERR_TH = CW'(ERR_TH);

   typedef enum logic [1:0] {
      ST_HEALTHY = 2'd0,
      ST_SUSPECT = 2'd1,
      ST_FAILED  = 2'd2
   } ch_st_t;

   ch_st_t           r_st  [3];
   logic [CW-1:0]    r_cnt [3];
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [2:0]       r_out_err;
   logic             r_no_maj;
   logic [CNT_W-1:0] r_err_total;

   logic [WIDTH-1:0] w_ch [3];
   logic [2:0]       w_fail;
   logic [1:0]       w_mode;
   logic             w_accept;
   logic [WIDTH-1:0] w_vote;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_s;
   logic [2:0]       w_err;
   logic             w_nomaj;

   assign w_ch[0] = ch_a;
   assign w_ch[1] = ch_b;
   assign w_ch[2] = ch_c;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         assign w_fail[gi] = (r_st[gi] == ST_FAILED);
      end
   endgenerate

   assign w_mode   = {1'b0, w_fail[0]} + {1'b0, w_fail[1]} + {1'b0, w_fail[2]};
   assign in_ready = !r_out_valid | out_ready;
   assign w_accept = in_valid & in_ready;

   always_comb begin
      // DMR pair: primary is the lower-lettered healthy channel
      w_p = ch_a;
      w_s = ch_b;
      if (w_fail[0]) begin
         w_p = ch_b;
         w_s = ch_c;
      end else if (w_fail[1]) begin
         w_s = ch_c;
      end
      w_vote  = ch_a;
      w_nomaj = 1'b0;
      case (w_mode)
         2'd0: w_vote = (ch_a & ch_b) | (ch_a & ch_c) | (ch_b & ch_c);
         2'd1: begin
            w_vote  = w_p;
            w_nomaj = (w_p != w_s);
         end
         2'd2: w_vote = !w_fail[0] ? ch_a : (!w_fail[1] ? ch_b : ch_c);
         default: begin
            w_vote  = ch_a;
            w_nomaj = 1'b1;
         end
      endcase
      w_err = '0;
      for (int i = 0; i < 3; i++) begin
         w_err[i] = !w_fail[i] && (w_ch[i] != w_vote);
      end
   end

   // Unattributable DMR disagreements leave every counter untouched
   always_ff @(posedge clk) begin
      if (rst || fail_clr) begin
         for (int i = 0; i < 3; i++) begin
            r_st[i]  <= ST_HEALTHY;
            r_cnt[i] <= '0;
         end
      end else if (w_accept && !w_nomaj) begin
         for (int i = 0; i < 3; i++) begin
            case (r_st[i])
               ST_HEALTHY, ST_SUSPECT: begin
                  if (w_err[i]) begin
                     r_cnt[i] <= r_cnt[i] + CW'(1);
                     r_st[i]  <= ((r_cnt[i] + CW'(1)) >= c_ERR_TH) ? ST_FAILED : ST_SUSPECT;
                  end else begin
                     r_cnt[i] <= '0;
                     r_st[i]  <= ST_HEALTHY;
                  end
               end
               default: begin
                  r_cnt[i] <= r_cnt[i];
                  r_st[i]  <= ST_FAILED;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_err   <= '0;
         r_no_maj    <= 1'b0;
         r_err_total <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_vote;
            r_out_err   <= w_err;
            r_no_maj    <= w_nomaj;
            if (((|w_err) || w_nomaj) && (r_err_total != {CNT_W{1'b1}})) begin
               r_err_total <= r_err_total + CNT_W'(1);
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_err   = r_out_err;
   assign no_maj    = r_no_maj;
   assign ch_fail   = w_fail;
   assign mode      = w_mode;
   assign err_total = r_err_total;

endmodule
`default_nettype wire

// File: tb/tb_tmr_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tmr_vote_ctrl
// Brief   : Directed plus randomized stimulus against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tmr_vote_ctrl;

   localparam int W      = 8;
   localparam int ERR_TH = 3;

   logic         clk = 1'b0;
   logic         rst, in_valid, fail_clr, out_ready;
   logic [W-1:0] ch_a, ch_b, ch_c;
   logic         in_ready, out_valid, no_maj;
   logic [W-1:0] out_data;
   logic [2:0]   out_err, ch_fail;
   logic [1:0]   mode;
   logic [7:0]   err_total;
   logic         in_ready2, out_valid2, no_maj2;
   logic [W-1:0] out_data2;
   logic [2:0]   out_err2, ch_fail2;
   logic [1:0]   mode2;
   logic [1:0]   err_total2;

   tmr_vote_ctrl #(.WIDTH(W), .ERR_TH(ERR_TH), .CW(2), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .fail_clr(fail_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .no_maj(no_maj), .ch_fail(ch_fail), .mode(mode),
      .err_total(err_total));

   tmr_vote_ctrl #(.WIDTH(W), .ERR_TH(ERR_TH), .CW(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .fail_clr(fail_clr),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_err(out_err2), .no_maj(no_maj2), .ch_fail(ch_fail2), .mode(mode2),
      .err_total(err_total2));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   bit         m_valid;
   logic [7:0] m_data;
   logic [2:0] m_err;
   bit         m_nomaj;
   bit         m_fl [3];
   int         m_cnt [3];
   int         m_total;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [7:0] ch [3];
      logic [7:0] v;
      int         h[$];
      int         ones;
      bit         acc;
      if (rst) begin
         m_valid = 0; m_data = '0; m_err = '0; m_nomaj = 0; m_total = 0;
         for (int i = 0; i < 3; i++) begin m_fl[i] = 0; m_cnt[i] = 0; end
         return;
      end
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
         ch[0] = ch_a; ch[1] = ch_b; ch[2] = ch_c;
         for (int i = 0; i < 3; i++) if (!m_fl[i]) h.push_back(i);
         m_nomaj = 0;
         if (h.size() == 3) begin
            for (int k = 0; k < 8; k++) begin
               ones = int'(ch[0][k]) + int'(ch[1][k]) + int'(ch[2][k]);
               v[k] = (ones >= 2);
            end
         end else if (h.size() == 2) begin
            v = ch[h[0]];
            m_nomaj = (ch[h[0]] != ch[h[1]]);
         end else if (h.size() == 1) begin
            v = ch[h[0]];
         end else begin
            v = ch[0];
            m_nomaj = 1;
         end
         m_data = v;
         for (int i = 0; i < 3; i++) m_err[i] = !m_fl[i] && (ch[i] != v);
         if (m_err != 0 || m_nomaj) m_total++;
         if (!fail_clr && !m_nomaj) begin
            for (int i = 0; i < 3; i++) begin
               if (!m_fl[i]) begin
                  if (m_err[i]) begin
                     m_cnt[i]++;
                     if (m_cnt[i] >= ERR_TH) m_fl[i] = 1;
                  end else begin
                     m_cnt[i] = 0;
                  end
               end
            end
         end
      end
      if (fail_clr) begin
         for (int i = 0; i < 3; i++) begin m_fl[i] = 0; m_cnt[i] = 0; end
      end
      m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
   endtask

   task automatic check_outputs();
      int nf;
      nf = int'(m_fl[0]) + int'(m_fl[1]) + int'(m_fl[2]);
      check_eq("out_valid", out_valid, m_valid);
      check_eq("out_data", out_data, m_data);
      check_eq("out_err", out_err, m_err);
      check_eq("no_maj", no_maj, m_nomaj);
      check_eq("ch_fail", ch_fail, {m_fl[2], m_fl[1], m_fl[0]});
      check_eq("mode", mode, nf);
      check_eq("err_total", err_total, (m_total > 255) ? 255 : m_total);
      check_eq("err_total_sat2", err_total2, (m_total > 3) ? 3 : m_total);
   endtask

   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic clr, input logic ordy, input logic r);
      rst = r; in_valid = v; ch_a = a; ch_b = b; ch_c = c; fail_clr = clr; out_ready = ordy;
      #1;
      if (!r) check_eq("in_ready", in_ready, !m_valid || ordy);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [7:0] base, a, b, c;
      int         bad;
      step(0, 8'h00, 8'h00, 8'h00, 0, 1, 1);
      step(0, 8'h00, 8'h00, 8'h00, 0, 1, 1);
      // TMR vote with c wrong, then a broken mismatch run
      step(1, 8'hF0, 8'hF0, 8'h0F, 0, 1, 0);
      step(1, 8'hF0, 8'hF0, 8'h0F, 0, 1, 0);
      step(1, 8'h33, 8'h33, 8'h33, 0, 1, 0);
      // three consecutive c mismatches retire c
      for (int i = 0; i < 3; i++) step(1, 8'h55, 8'h55, 8'hAA, 0, 1, 0);
      step(1, 8'h11, 8'h22, 8'h99, 0, 1, 0);
      step(1, 8'h44, 8'h44, 8'h00, 0, 1, 0);
      // backpressure with distinct samples offered
      for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 8'(8'h60 + i), 8'(8'h60 + i), 0, 0, 0);
      step(1, 8'h70, 8'h70, 8'h70, 0, 1, 0);
      step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      // fail_clr together with a wrong sample
      step(1, 8'h7E, 8'h81, 8'h81, 1, 1, 0);
      step(1, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0);
      // reset while an output is pending
      step(1, 8'h12, 8'h34, 8'h56, 0, 0, 1);
      step(0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      bad = 2;
      for (int n = 0; n < 1500; n++) begin
         if (n % 40 == 0) bad = $urandom_range(0, 3);
         base = 8'($urandom);
         a = base; b = base; c = base;
         if ((bad == 0 && $urandom_range(0, 9) < 7) || $urandom_range(0, 99) < 3) a = 8'($urandom);
         if ((bad == 1 && $urandom_range(0, 9) < 7) || $urandom_range(0, 99) < 3) b = 8'($urandom);
         if ((bad == 2 && $urandom_range(0, 9) < 7) || $urandom_range(0, 99) < 3) c = 8'($urandom);
         step($urandom_range(0, 99) < 85, a, b, c, $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 70, $urandom_range(0, 199) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
